// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: walks active-low rows, samples active-low columns once per row dwell,
// classifies each full scan and debounces single-key presses/releases into registered events.
module keypad_scan_debounce #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DWELL    = 1000,
    parameter int DEBOUNCE = 4,
    localparam int KEY_W   = $clog2(ROWS*COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COLS-1:0]  SWC,
    output logic [ROWS-1:0]  SWR,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_release,
    output logic             key_held,
    output logic             multi_key
);

    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(DWELL);
    localparam int DW  = $clog2(DEBOUNCE+1);
    localparam int CLW = $clog2(COLS);

    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL-1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS-1);
    localparam logic [DW-1:0]   DEB_LAST   = DW'(DEBOUNCE-1);
    localparam logic [ROWS-1:0] SWR_INIT   = {{(ROWS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEB  = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    logic [CW-1:0]    dwell_r;
    logic [RW-1:0]    row_idx_r;
    logic [ROWS-1:0]  swr_r;
    logic [1:0]       acc_cnt_r;
    logic [KEY_W-1:0] acc_code_r;
    logic             acc_found_r;
    logic [1:0]       res_cnt_r;
    logic [KEY_W-1:0] res_code_r;
    logic             scan_end_r;

    state_t           state_r;
    logic [DW-1:0]    deb_cnt_r;
    logic [KEY_W-1:0] cand_r;
    logic [KEY_W-1:0] key_r;
    logic             key_valid_r;
    logic             key_release_r;
    logic             key_held_r;
    logic             multi_r;

    logic [1:0]       row_hits_s;
    logic [CLW-1:0]   row_col_s;
    logic             row_any_s;
    logic [2:0]       sum_s;
    logic [1:0]       total_s;
    logic [KEY_W-1:0] row_code_s;
    logic [KEY_W-1:0] cand_s;
    logic             found_s;

    // Closure count (saturating at 2) and lowest closed column for the row currently driven.
    always_comb begin
        row_hits_s = 2'd0;
        row_col_s  = {CLW{1'b0}};
        row_any_s  = 1'b0;
        for (int c = COLS-1; c >= 0; c--) begin
            if (!SWC[c]) begin
                row_col_s = CLW'(c);
                row_any_s = 1'b1;
                if (row_hits_s != 2'd2) begin
                    row_hits_s = row_hits_s + 2'd1;
                end else begin
                    row_hits_s = row_hits_s;
                end
            end else begin
                row_col_s = row_col_s;
            end
        end
        sum_s      = {1'b0, acc_cnt_r} + {1'b0, row_hits_s};
        total_s    = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        row_code_s = KEY_W'(row_idx_r) * KEY_W'(COLS) + KEY_W'(row_col_s);
        cand_s     = acc_found_r ? acc_code_r : row_code_s;
        found_s    = acc_found_r | row_any_s;
    end

    // Row sequencer and per-scan accumulation; the first closed row seen keeps the candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_r     <= {CW{1'b0}};
            row_idx_r   <= {RW{1'b0}};
            swr_r       <= SWR_INIT;
            acc_cnt_r   <= 2'd0;
            acc_code_r  <= {KEY_W{1'b0}};
            acc_found_r <= 1'b0;
            res_cnt_r   <= 2'd0;
            res_code_r  <= {KEY_W{1'b0}};
            scan_end_r  <= 1'b0;
        end else begin
            scan_end_r <= 1'b0;
            if (dwell_r == DWELL_LAST) begin
                dwell_r <= {CW{1'b0}};
                swr_r   <= {swr_r[ROWS-2:0], swr_r[ROWS-1]};
                if (row_idx_r == ROW_LAST) begin
                    row_idx_r   <= {RW{1'b0}};
                    res_cnt_r   <= total_s;
                    res_code_r  <= cand_s;
                    acc_cnt_r   <= 2'd0;
                    acc_code_r  <= {KEY_W{1'b0}};
                    acc_found_r <= 1'b0;
                    scan_end_r  <= 1'b1;
                end else begin
                    row_idx_r   <= row_idx_r + RW'(1);
                    acc_cnt_r   <= total_s;
                    acc_code_r  <= cand_s;
                    acc_found_r <= found_s;
                end
            end else begin
                dwell_r <= dwell_r + CW'(1);
            end
        end
    end

    // Debounce FSM, stepped once per completed scan; strobes default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            deb_cnt_r     <= {DW{1'b0}};
            cand_r        <= {KEY_W{1'b0}};
            key_r         <= {KEY_W{1'b0}};
            key_valid_r   <= 1'b0;
            key_release_r <= 1'b0;
            key_held_r    <= 1'b0;
            multi_r       <= 1'b0;
        end else begin
            key_valid_r   <= 1'b0;
            key_release_r <= 1'b0;
            if (scan_end_r) begin
                multi_r <= (res_cnt_r == 2'd2);
                case (state_r)
                    ST_IDLE: begin
                        if (res_cnt_r == 2'd1) begin
                            cand_r <= res_code_r;
                            if (DEBOUNCE == 1) begin
                                key_r       <= res_code_r;
                                key_valid_r <= 1'b1;
                                key_held_r  <= 1'b1;
                                deb_cnt_r   <= {DW{1'b0}};
                                state_r     <= ST_HELD;
                            end else begin
                                deb_cnt_r <= DW'(1);
                                state_r   <= ST_DEB;
                            end
                        end else begin
                            deb_cnt_r <= {DW{1'b0}};
                        end
                    end
                    ST_DEB: begin
                        if (res_cnt_r == 2'd1 && res_code_r == cand_r) begin
                            if (deb_cnt_r == DEB_LAST) begin
                                key_r       <= cand_r;
                                key_valid_r <= 1'b1;
                                key_held_r  <= 1'b1;
                                deb_cnt_r   <= {DW{1'b0}};
                                state_r     <= ST_HELD;
                            end else begin
                                deb_cnt_r <= deb_cnt_r + DW'(1);
                            end
                        end else if (res_cnt_r == 2'd1) begin
                            cand_r    <= res_code_r;
                            deb_cnt_r <= DW'(1);
                        end else begin
                            deb_cnt_r <= {DW{1'b0}};
                            state_r   <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        // Any closure, including a different or second key, restarts the release count.
                        if (res_cnt_r == 2'd0) begin
                            if (deb_cnt_r == DEB_LAST) begin
                                key_release_r <= 1'b1;
                                key_held_r    <= 1'b0;
                                deb_cnt_r     <= {DW{1'b0}};
                                state_r       <= ST_IDLE;
                            end else begin
                                deb_cnt_r <= deb_cnt_r + DW'(1);
                            end
                        end else begin
                            deb_cnt_r <= {DW{1'b0}};
                        end
                    end
                    default: begin
                        deb_cnt_r  <= {DW{1'b0}};
                        key_held_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                endcase
            end else begin
                multi_r <= multi_r;
            end
        end
    end

    assign SWR         = swr_r;
    assign key         = key_r;
    assign key_valid   = key_valid_r;
    assign key_release = key_release_r;
    assign key_held    = key_held_r;
    assign multi_key   = multi_r;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce: a 4x4 switch matrix model drives SWC from SWR,
// and expected event timing is computed from the 16-cycle scan period (DWELL=4, DEBOUNCE=3).
module tb_keypad_scan_debounce;

    logic        clk;
    logic        rst;
    logic [3:0]  swc;
    logic [3:0]  swr;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_release;
    logic        key_held;
    logic        multi_key;

    logic [15:0] keys;
    int          cyc;
    int          kv_cnt;
    int          kr_cnt;
    int          both_cnt;
    int          checks;
    int          failures;
    int          kv_base;

    keypad_scan_debounce #(
        .ROWS(4), .COLS(4), .DWELL(4), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .rst(rst), .SWC(swc), .SWR(swr), .key(key),
        .key_valid(key_valid), .key_release(key_release),
        .key_held(key_held), .multi_key(multi_key)
    );

    function automatic logic [3:0] sense(input logic [3:0] rows, input logic [15:0] closed);
        logic [3:0] v;
        v = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows[r] && closed[r*4+c]) v[c] = 1'b0;
            end
        end
        return v;
    endfunction

    assign swc = sense(swr, keys);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Strobe counters sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid)                kv_cnt   <= kv_cnt + 1;
            if (key_release)              kr_cnt   <= kr_cnt + 1;
            if (key_valid && key_release) both_cnt <= both_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0; failures = 0; kv_cnt = 0; kr_cnt = 0; both_cnt = 0;
        keys = 16'h0000;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_swr", 32'(swr), 32'hE);
        chk("rst_key", 32'(key), 32'h0);
        chk("rst_kv", 32'(key_valid), 32'h0);
        chk("rst_kr", 32'(key_release), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        chk("rst_multi", 32'(multi_key), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Row walk with no keys.
        chk("swr_c0", 32'(swr), 32'hE);
        at(3);  chk("swr_c3", 32'(swr), 32'hE);
        at(4);  chk("swr_c4", 32'(swr), 32'hD);
        at(8);  chk("swr_c8", 32'(swr), 32'hB);
        at(12); chk("swr_c12", 32'(swr), 32'h7);
        at(16); chk("swr_wrap", 32'(swr), 32'hE);
        at(40);
        chk("idle_kv", 32'(kv_cnt), 32'd0);
        chk("idle_kr", 32'(kr_cnt), 32'd0);
        chk("idle_multi", 32'(multi_key), 32'h0);

        // Press row1/col2 from the start of scan 3: accepted after scans 3,4,5.
        at(48); keys = 16'h0040;
        at(96);
        chk("press_kv_early", 32'(key_valid), 32'h0);
        chk("press_held_early", 32'(key_held), 32'h0);
        at(97);
        chk("press_kv", 32'(key_valid), 32'h1);
        chk("press_key", 32'(key), 32'd6);
        chk("press_held", 32'(key_held), 32'h1);
        at(98);
        chk("press_kv_width", 32'(key_valid), 32'h0);
        at(418);
        chk("hold_no_repeat", 32'(kv_cnt), 32'd1);
        chk("hold_held", 32'(key_held), 32'h1);
        chk("hold_multi", 32'(multi_key), 32'h0);

        // Second key while held.
        at(432); keys = 16'h0041;
        at(449);
        chk("held_multi_1", 32'(multi_key), 32'h1);
        chk("held_multi_held", 32'(key_held), 32'h1);
        at(481);
        chk("held_multi_2", 32'(multi_key), 32'h1);
        chk("held_multi_kv", 32'(kv_cnt), 32'd1);
        chk("held_multi_kr", 32'(kr_cnt), 32'd0);

        // Release: three empty scans 31..33.
        at(496); keys = 16'h0000;
        at(513);
        chk("rel_multi_clr", 32'(multi_key), 32'h0);
        chk("rel_held_mid", 32'(key_held), 32'h1);
        at(544);
        chk("rel_kr_early", 32'(key_release), 32'h0);
        chk("rel_held_early", 32'(key_held), 32'h1);
        at(545);
        chk("rel_kr", 32'(key_release), 32'h1);
        chk("rel_held", 32'(key_held), 32'h0);
        chk("rel_key_kept", 32'(key), 32'd6);
        at(546);
        chk("rel_kr_width", 32'(key_release), 32'h0);
        chk("rel_kr_cnt", 32'(kr_cnt), 32'd1);

        // Bounce on row2/col1: closed 2 scans, open 1, five times.
        for (int i = 0; i < 5; i++) begin
            at(560 + 48*i); keys = 16'h0200;
            at(592 + 48*i); keys = 16'h0000;
        end
        at(802);
        chk("bounce_kv", 32'(kv_cnt), 32'd1);
        chk("bounce_key", 32'(key), 32'd6);
        chk("bounce_held", 32'(key_held), 32'h0);

        // Two keys from idle.
        at(816); keys = 16'h8001;
        at(832); chk("multi_before", 32'(multi_key), 32'h0);
        at(833); chk("multi_s51", 32'(multi_key), 32'h1);
        at(849); chk("multi_s52", 32'(multi_key), 32'h1);
        at(865); chk("multi_s53", 32'(multi_key), 32'h1);
        at(880); keys = 16'h0000;
        at(897);
        chk("multi_clear", 32'(multi_key), 32'h0);
        chk("multi_kv", 32'(kv_cnt), 32'd1);
        chk("multi_held", 32'(key_held), 32'h0);

        // Reset two scans into a debounce; the press must restart from scratch.
        at(912); keys = 16'h0040;
        at(950);
        rst = 1'b1;
        #1;
        chk("mid_rst_swr", 32'(swr), 32'hE);
        chk("mid_rst_key", 32'(key), 32'h0);
        chk("mid_rst_held", 32'(key_held), 32'h0);
        chk("mid_rst_multi", 32'(multi_key), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        kv_base = kv_cnt;
        at(48);
        chk("rst_press_early", 32'(key_valid), 32'h0);
        chk("rst_press_cnt", 32'(kv_cnt), 32'(kv_base));
        at(49);
        chk("rst_press_kv", 32'(key_valid), 32'h1);
        chk("rst_press_key", 32'(key), 32'd6);
        chk("rst_press_held", 32'(key_held), 32'h1);
        at(50);
        chk("strobe_overlap", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
